// File: rtl/mlaccel_smem_arbiter.sv
// mlaccel_smem_arbiter: shares single-port smem between host (r/w) and sequencer fetch (ro)
module mlaccel_smem_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter bit HOST_PRIORITY = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic        host_write,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  input  logic [3:0]  host_wstrb,
  output logic [31:0] host_rdata,
  input  logic        seq_valid,
  output logic        seq_ready,
  input  logic [15:0] seq_addr,
  output logic [31:0] seq_rdata,
  output logic        mem_ren,
  output logic [3:0]  mem_wen,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic grant, last_grant, write, win_seq;
  logic [1:0] cnt;
  // grant encoding: 0 = host, 1 = sequencer
  assign win_seq = seq_valid & (~host_valid | (!HOST_PRIORITY && !last_grant));
  assign busy = state != IDLE;
  // ready is dropped if the requester abandoned its access before the response
  assign host_ready = state == RESP && !grant && host_valid;
  assign seq_ready = state == RESP && grant && seq_valid;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      grant <= 1'b0;
      last_grant <= 1'b0;
      write <= 1'b0;
      cnt <= 2'd0;
      mem_ren <= 1'b0;
      mem_wen <= 4'd0;
      mem_addr <= 16'd0;
      mem_wdata <= 32'd0;
      host_rdata <= 32'd0;
      seq_rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: if (host_valid || seq_valid) begin
          grant <= win_seq;
          last_grant <= win_seq;
          write <= ~win_seq & host_write;
          mem_addr <= win_seq ? seq_addr : host_addr;
          mem_wdata <= win_seq ? 32'd0 : host_wdata;
          mem_ren <= win_seq | ~host_write;
          mem_wen <= (~win_seq & host_write) ? host_wstrb : 4'd0;
          state <= ISSUE;
        end
        ISSUE: begin
          mem_ren <= 1'b0;
          mem_wen <= 4'd0;
          cnt <= 2'(MEM_LATENCY - 1);
          state <= WAIT;
        end
        WAIT: if (cnt == 2'd0) begin
          if (grant) seq_rdata <= mem_rdata;
          else if (!write) host_rdata <= mem_rdata;
          state <= RESP;
        end else cnt <= cnt - 2'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mlaccel_smem_arbiter.sv
// tb_mlaccel_smem_arbiter: directed checks on three arbiter configs (L1/RR, L2/RR, L3/host-priority)
module tb_mlaccel_smem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] hv, sv, hr, sr, ren, busy, pre;
  logic hw;
  logic [15:0] ha, sa;
  logic [31:0] hwd, pd;
  logic [3:0] hws;
  logic [7:0] pa;
  logic [31:0] hrd [3];
  logic [31:0] srd [3];
  logic [31:0] mwd [3];
  logic [31:0] mrd [3];
  logic [15:0] maddr [3];
  logic [3:0] wen [3];
  int total = 0;
  int fails = 0;
  always #5 clk = ~clk;
  for (genvar i = 0; i < 3; i++) begin : g
    localparam int L = i + 1;
    logic [31:0] ram [256];
    logic [31:0] pipe [4];
    mlaccel_smem_arbiter #(.MEM_LATENCY(L), .HOST_PRIORITY(i == 2)) dut (
      .clock(clk), .reset(rst),
      .host_valid(hv[i]), .host_ready(hr[i]), .host_write(hw), .host_addr(ha),
      .host_wdata(hwd), .host_wstrb(hws), .host_rdata(hrd[i]),
      .seq_valid(sv[i]), .seq_ready(sr[i]), .seq_addr(sa), .seq_rdata(srd[i]),
      .mem_ren(ren[i]), .mem_wen(wen[i]), .mem_addr(maddr[i]), .mem_wdata(mwd[i]),
      .mem_rdata(mrd[i]), .busy(busy[i])
    );
    // RAM model: data read at mem_ren appears on mem_rdata L cycles later
    always @(posedge clk) begin
      if (ren[i]) pipe[0] <= ram[maddr[i][7:0]];
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
      for (int b = 0; b < 4; b++) if (wen[i][b]) ram[maddr[i][7:0]][8*b +: 8] <= mwd[i][8*b +: 8];
      if (pre[i]) ram[pa] <= pd;
    end
    assign mrd[i] = pipe[L-1];
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic load(input int i, input logic [7:0] a, input logic [31:0] d);
    pre = 3'd0;
    pre[i] = 1'b1;
    pa = a;
    pd = d;
    tick;
    pre = 3'd0;
  endtask
  task automatic chk_reset(input int i, input string tag);
    chk({tag, "_hready"}, hr[i], 0);
    chk({tag, "_sready"}, sr[i], 0);
    chk({tag, "_ren"}, ren[i], 0);
    chk({tag, "_wen"}, wen[i], 0);
    chk({tag, "_addr"}, maddr[i], 0);
    chk({tag, "_wdata"}, mwd[i], 0);
    chk({tag, "_hrdata"}, hrd[i], 0);
    chk({tag, "_srdata"}, srd[i], 0);
    chk({tag, "_busy"}, busy[i], 0);
  endtask
  initial begin
    rst = 1'b1; hv = 3'd0; sv = 3'd0; hw = 1'b0; ha = 16'd0; sa = 16'd0;
    hwd = 32'd0; hws = 4'd0; pre = 3'd0; pa = 8'd0; pd = 32'd0;
    tick; tick;
    load(0, 8'h10, 32'hDEADBEEF);
    load(0, 8'h04, 32'hAAAABBBB);
    load(1, 8'h04, 32'h55556666);
    load(1, 8'h10, 32'h77778888);
    load(2, 8'h10, 32'h11112222);
    load(2, 8'h04, 32'h33334444);
    for (int i = 0; i < 3; i++) chk_reset(i, "reset");
    rst = 1'b0;
    // host read, latency 1
    hv[0] = 1'b1; ha = 16'h0010;
    tick;
    chk("rd_ren", ren[0], 1);
    chk("rd_addr", maddr[0], 32'h0010);
    chk("rd_busy", busy[0], 1);
    chk("rd_ready_early", hr[0], 0);
    tick;
    chk("rd_ren_once", ren[0], 0);
    chk("rd_ready_c2", hr[0], 0);
    tick;
    chk("rd_ready", hr[0], 1);
    chk("rd_data", hrd[0], 32'hDEADBEEF);
    chk("rd_no_sready", sr[0], 0);
    hv[0] = 1'b0;
    tick;
    chk("rd_ready_single", hr[0], 0);
    chk("rd_idle", busy[0], 0);
    // host partial write
    hv[0] = 1'b1; hw = 1'b1; ha = 16'h0004; hwd = 32'h12345678; hws = 4'b0011;
    tick;
    chk("wr_wen", wen[0], 4'b0011);
    chk("wr_ren", ren[0], 0);
    chk("wr_wdata", mwd[0], 32'h12345678);
    ha = 16'h0020; hwd = 32'hFFFFFFFF;
    tick;
    chk("wr_wen_once", wen[0], 0);
    tick;
    chk("wr_ready", hr[0], 1);
    chk("wr_rdata_hold", hrd[0], 32'hDEADBEEF);
    hv[0] = 1'b0; hw = 1'b0;
    tick;
    // sequencer reads back the merged word
    sv[0] = 1'b1; sa = 16'h0004;
    tick;
    chk("sq_ren", ren[0], 1);
    chk("sq_wen", wen[0], 0);
    tick; tick;
    chk("sq_ready", sr[0], 1);
    chk("sq_data", srd[0], 32'hAAAA5678);
    chk("sq_hrdata_hold", hrd[0], 32'hDEADBEEF);
    sv[0] = 1'b0;
    tick;
    // round-robin contention from a fresh reset
    rst = 1'b1;
    tick;
    rst = 1'b0;
    hv[0] = 1'b1; sv[0] = 1'b1; ha = 16'h0010; sa = 16'h0004;
    for (int t = 0; t < 4; t++) begin
      tick; tick; tick;
      chk("rr_seq", sr[0], (t % 2 == 0));
      chk("rr_host", hr[0], (t % 2 == 1));
      chk("rr_data", (t % 2 == 1) ? hrd[0] : srd[0], (t % 2 == 1) ? 32'hDEADBEEF : 32'hAAAA5678);
      tick;
    end
    hv[0] = 1'b0; sv[0] = 1'b0;
    tick; tick; tick; tick;
    // host priority, latency 3
    hv[2] = 1'b1; sv[2] = 1'b1;
    repeat (5) tick;
    chk("pri_host1", hr[2], 1);
    chk("pri_seq1", sr[2], 0);
    chk("pri_data1", hrd[2], 32'h11112222);
    tick;
    repeat (5) tick;
    chk("pri_host2", hr[2], 1);
    chk("pri_seq2", sr[2], 0);
    hv[2] = 1'b0;
    tick;
    repeat (5) tick;
    chk("pri_seq3", sr[2], 1);
    chk("pri_sdata", srd[2], 32'h33334444);
    sv[2] = 1'b0;
    tick;
    // sequencer abort, latency 2
    sv[1] = 1'b1; sa = 16'h0004;
    tick;
    chk("ab_ren", ren[1], 1);
    chk("ab_addr", maddr[1], 32'h0004);
    tick;
    sv[1] = 1'b0;
    chk("ab_sready_c2", sr[1], 0);
    tick;
    chk("ab_sready_c3", sr[1], 0);
    tick;
    chk("ab_sready_c4", sr[1], 0);
    chk("ab_busy_c4", busy[1], 1);
    tick;
    chk("ab_idle_c5", busy[1], 0);
    hv[1] = 1'b1; ha = 16'h0010;
    repeat (4) tick;
    chk("ab_next_ready", hr[1], 1);
    chk("ab_next_data", hrd[1], 32'h77778888);
    hv[1] = 1'b0;
    tick;
    // reset while waiting on memory, latency 3
    hv[2] = 1'b1; ha = 16'h0010;
    tick;
    chk("rw_issue", ren[2], 1);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    hv[2] = 1'b0;
    chk_reset(2, "rw");
    for (int c = 0; c < 6; c++) begin
      tick;
      chk("rw_no_ready", hr[2], 0);
    end
    chk("rw_idle", busy[2], 0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/mlaccel_smem_arbiter.md
Name: mlaccel_smem_arbiter

Overview:
- Shares the single-port sequencer memory (smem) between two requesters: the host interface (read/write) and the sequencer instruction fetch (read-only).
- Sits between the host bridge, the mlaccel_sequencer smem_* port, and the smem RAM macro.
- Each access is a single-beat transaction. Requester holds valid; the arbiter pulses ready for one cycle with read data in the same cycle.
- Fair round-robin arbitration, with an optional fixed host priority.

Parameters:
- MEM_LATENCY, 1: cycles from mem_ren/mem_wen asserted to mem_rdata valid (1..4).
- HOST_PRIORITY, 0: 0 = round-robin on contention; 1 = host always wins contention.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- host_valid  in  1  host request pending; held until host_ready
- host_ready  out  1  one-cycle completion pulse for host
- host_write  in  1  1 = write, 0 = read
- host_addr  in  16  word address
- host_wdata  in  32  write data
- host_wstrb  in  4  byte enables for writes
- host_rdata  out  32  read data, valid while host_ready=1
- seq_valid  in  1  sequencer fetch pending; held until seq_ready
- seq_ready  out  1  one-cycle completion pulse for sequencer
- seq_addr  in  16  fetch address
- seq_rdata  out  32  fetch data, valid while seq_ready=1
- mem_ren  out  1  RAM read enable
- mem_wen  out  4  RAM byte write enables
- mem_addr  out  16  RAM address
- mem_wdata  out  32  RAM write data
- mem_rdata  in  32  RAM read data
- busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset values: all ready/enable outputs 0; mem_addr, mem_wdata, host_rdata, seq_rdata 0; state IDLE; last_grant = HOST (first contention goes to SEQ).
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If host_valid or seq_valid, select a winner and latch grant, addr, write, wdata, wstrb; go to ISSUE.
  - Otherwise stay.
- Winner selection:
  - One valid: that requester.
  - Both valid, HOST_PRIORITY=1: host.
  - Both valid, HOST_PRIORITY=0: the requester not equal to last_grant.
  - last_grant is updated on every grant.
- ISSUE (exactly 1 cycle):
  - Read: mem_ren=1.
  - Write: mem_wen=latched wstrb and mem_ren=0.
  - mem_addr/mem_wdata hold latched values.
  - Go to WAIT with counter = MEM_LATENCY-1; if MEM_LATENCY=1, go directly to capture.
- WAIT:
  - mem_ren/mem_wen = 0; counter decrements each cycle.
  - In the cycle mem_rdata is valid (MEM_LATENCY cycles after ISSUE), capture it into the granted requester's rdata register; go to RESP.
- RESP (1 cycle):
  - Assert the granted ready only if that requester's valid is still 1.
  - If valid was dropped mid-transaction (sequencer restart), discard the response with no ready pulse; the memory access has already occurred.
  - Return to IDLE.
- Latency: valid seen in IDLE at cycle T gives ISSUE at T+1 and ready at T+2+MEM_LATENCY.
- Throughput: one access per MEM_LATENCY+3 cycles.
- Requesters drop valid on the ready edge. Because of the IDLE state, a just-served requester is never re-granted on stale valid.
- Writes also complete with a host_ready pulse at the same latency; host_rdata is undefined-but-stable for writes (holds the previous value).
- seq_rdata/host_rdata hold their values between pulses. Only the granted side's register updates.
- Request fields are latched at grant; later changes on *_addr/*_wdata while valid is held are ignored.
- host_write for seq is implicitly 0. mem_wen is never nonzero on a sequencer grant.
- Reset mid-operation (any state): immediately IDLE, outputs to reset values, in-flight transaction abandoned, no ready pulse.
- busy = 1 in ISSUE, WAIT and RESP.

Test Plan:
- Single host read, MEM_LATENCY=1: host_valid at cycle 0, addr 0x0010, RAM word 0xDEADBEEF -> mem_ren=1 with mem_addr=0x0010 at cycle 1; host_ready=1 and host_rdata=0xDEADBEEF at cycle 3, single pulse.
- Host write: addr 0x0004, wdata 0x12345678, wstrb 4'b0011 -> mem_wen=4'b0011 for exactly one cycle, mem_ren=0; host_ready pulse at T+3. A subsequent seq read of 0x0004 returns the low halfword 0x5678 with the upper halfword unchanged.
- Contention, HOST_PRIORITY=0: both valid continuously for 4 transactions -> grant order SEQ, HOST, SEQ, HOST. No back-to-back grant to the same side while both are valid.
- Contention, HOST_PRIORITY=1: both valid -> host served first. Seq is served only after host_valid drops.
- Seq abort: seq_valid at cycle 0, deasserted at cycle 2, MEM_LATENCY=2 -> memory read still issued at cycle 1, no seq_ready pulse, busy=0 by cycle 5, next request accepted.
- Reset in WAIT with MEM_LATENCY=3: reset pulse at cycle 2 -> at cycle 3 all outputs are 0 and state is IDLE; no ready pulse ever appears for the aborted access.
